// File: rtl/ps2_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
package ps2_tx_pkg;

    // Transmit FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StData,
        StAck,
        StWaitIdle
    } state_e;

    // Shifted frame: {stop, parity, d[7:0]}; the start bit is driven on entry to RTS.
    localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/ps2_tx_if.sv
// Command handshake between the host logic and the PS/2 transmitter.
interface ps2_tx_if;

    logic       tx;
    logic [7:0] d;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output tx, d, input busy, done, err);
    modport slave  (input tx, d, output busy, done, err);

endinterface

// File: rtl/ps2_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers, ck debounce and ck falling-edge pulse.
module ps2_filter #(
    parameter int unsigned FILTER = 8
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_ce,
    input  logic i_ck,
    input  logic i_dq,
    output logic o_ck,
    output logic o_ck_fall,
    output logic o_dq
);

    localparam int unsigned CW = $clog2(FILTER + 1);

    logic [1:0]    r_ck_sync;
    logic [1:0]    r_dq_sync;
    logic          r_ck_filt;
    logic          r_ck_fall;
    logic [CW-1:0] r_cnt;

    // Synchronise both asynchronous pin levels; idle lines are high.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_ck_sync <= 2'b11;
            r_dq_sync <= 2'b11;
        end else begin
            r_ck_sync <= {r_ck_sync[0], i_ck};
            r_dq_sync <= {r_dq_sync[0], i_dq};
        end
    end

    // Accept a ck level change after FILTER consecutive differing ce samples.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_ck_filt <= 1'b1;
            r_ck_fall <= 1'b0;
            r_cnt     <= '0;
        end else if (i_ce) begin
            r_ck_fall <= 1'b0;
            if (r_ck_sync[1] == r_ck_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER - 1)) begin
                r_ck_filt <= r_ck_sync[1];
                r_cnt     <= '0;
                // Flipping away from 1 means a falling edge; held for exactly one ce period.
                r_ck_fall <= r_ck_filt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_ck      = r_ck_filt;
    assign o_ck_fall = r_ck_fall;
    assign o_dq      = r_dq_sync[1];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10-bit frame, ack check.
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int unsigned INHIBIT = 700,
    parameter int unsigned TIMEOUT = 105000,
    parameter int unsigned FILTER  = 8
) (
    input  logic    i_clock,
    input  logic    i_reset,
    input  logic    i_ce,
    ps2_tx_if.slave bus,
    input  logic    i_ps2_ck,
    input  logic    i_ps2_dq,
    output logic    o_ps2_ck_oe,
    output logic    o_ps2_dq_oe
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned IW = $clog2(INHIBIT + 1);

    state_e                r_state, w_state_d;
    logic [FRAME_BITS-1:0] r_frame, w_frame_d;
    logic [3:0]            r_idx, w_idx_d;
    logic [IW-1:0]         r_inh, w_inh_d;
    logic [TW-1:0]         r_to, w_to_d;
    logic                  r_busy, w_busy_d;
    logic                  r_done, w_done_d;
    logic                  r_err, w_err_d;
    logic                  r_ck_oe, w_ck_oe_d;
    logic                  r_dq_oe, w_dq_oe_d;
    logic                  w_abort;
    logic                  w_ck;
    logic                  w_ck_fall;
    logic                  w_dq;

    ps2_filter #(
        .FILTER (FILTER)
    ) u_filter (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_ce      (i_ce),
        .i_ck      (i_ps2_ck),
        .i_dq      (i_ps2_dq),
        .o_ck      (w_ck),
        .o_ck_fall (w_ck_fall),
        .o_dq      (w_dq)
    );

    // State and registered outputs; reset releases both lines without a clock edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_frame <= '0;
            r_idx   <= '0;
            r_inh   <= '0;
            r_to    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ck_oe <= 1'b0;
            r_dq_oe <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_frame <= w_frame_d;
            r_idx   <= w_idx_d;
            r_inh   <= w_inh_d;
            r_to    <= w_to_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
            r_ck_oe <= w_ck_oe_d;
            r_dq_oe <= w_dq_oe_d;
        end
    end

    // Next-state logic; everything advances only on ce.
    always_comb begin
        w_state_d = r_state;
        w_frame_d = r_frame;
        w_idx_d   = r_idx;
        w_inh_d   = r_inh;
        w_to_d    = r_to;
        w_busy_d  = r_busy;
        w_done_d  = r_done;
        w_err_d   = r_err;
        w_ck_oe_d = r_ck_oe;
        w_dq_oe_d = r_dq_oe;
        w_abort   = 1'b0;
        if (i_ce) begin
            w_done_d = 1'b0;
            w_err_d  = 1'b0;
            if (r_state inside {StRts, StData, StAck, StWaitIdle}) begin
                if (r_to <= TW'(1)) begin
                    w_abort = 1'b1;
                end else begin
                    w_to_d = r_to - TW'(1);
                end
            end
            case (r_state)
                StIdle: begin
                    // A strobe coinciding with a done/err pulse is dropped.
                    if (bus.tx && !r_done && !r_err) begin
                        w_frame_d = {1'b1, ~^bus.d, bus.d};
                        w_busy_d  = 1'b1;
                        w_inh_d   = IW'(INHIBIT);
                        w_ck_oe_d = 1'b1;
                        w_dq_oe_d = 1'b0;
                        w_state_d = StInhibit;
                    end
                end
                StInhibit: begin
                    if (r_inh <= IW'(1)) begin
                        w_ck_oe_d = 1'b0;
                        w_dq_oe_d = 1'b1;
                        w_to_d    = TW'(TIMEOUT);
                        w_state_d = StRts;
                    end else begin
                        w_inh_d = r_inh - IW'(1);
                    end
                end
                StRts: begin
                    if (w_ck_fall) begin
                        w_dq_oe_d = ~r_frame[0];
                        w_frame_d = r_frame >> 1;
                        w_idx_d   = 4'd1;
                        w_state_d = StData;
                    end
                end
                StData: begin
                    if (w_ck_fall) begin
                        w_dq_oe_d = ~r_frame[0];
                        w_frame_d = r_frame >> 1;
                        w_idx_d   = r_idx + 4'd1;
                        if (r_idx == 4'(FRAME_BITS - 1)) begin
                            w_state_d = StAck;
                        end
                    end
                end
                StAck: begin
                    if (w_ck_fall) begin
                        if (!w_dq) begin
                            w_state_d = StWaitIdle;
                        end else begin
                            w_abort = 1'b1;
                        end
                    end
                end
                StWaitIdle: begin
                    if (w_ck && w_dq) begin
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                        w_state_d = StIdle;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
            // Abort overrides any completion on the same tick so done and err stay exclusive.
            if (w_abort) begin
                w_ck_oe_d = 1'b0;
                w_dq_oe_d = 1'b0;
                w_busy_d  = 1'b0;
                w_done_d  = 1'b0;
                w_err_d   = 1'b1;
                w_state_d = StIdle;
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign o_ps2_ck_oe = r_ck_oe;
    assign o_ps2_dq_oe = r_dq_oe;

endmodule
